// File: rtl/gamma_plane_packer_pkg.sv
// Shared constants for the gamma plane packer: default widths, plane index
// encoding, assembler states and the packed pixel width helper.
package gamma_plane_packer_pkg;

  localparam int GPP_DATA_WIDTH  = 10;
  localparam int GPP_CPSEL_WIDTH = 2;
  localparam int GPP_NUM_CP      = 3;
  localparam int GPP_FIFO_DEPTH  = 8;

  localparam int CP0 = 0;
  localparam int CP1 = 1;
  localparam int CP2 = 2;

  typedef enum logic {
    ASM_IDLE    = 1'b0,
    ASM_COLLECT = 1'b1
  } asm_state_e;

  // Packed pixel width, kept in step with the gamma corrector configuration.
  function automatic int pix_width(input int num_cp, input int data_width);
    return num_cp * data_width;
  endfunction

endpackage

// File: rtl/gamma_plane_packer_if.sv
// Plane input stream from the gamma corrector and pixel output stream toward
// the output formatter.
interface gamma_plane_packer_if #(
  parameter int DATA_WIDTH  = gamma_plane_packer_pkg::GPP_DATA_WIDTH,
  parameter int NUM_CP      = gamma_plane_packer_pkg::GPP_NUM_CP,
  parameter int CPSEL_WIDTH = gamma_plane_packer_pkg::GPP_CPSEL_WIDTH
);

  logic                         inpvalid;
  logic [DATA_WIDTH-1:0]        din;
  logic [CPSEL_WIDTH-1:0]       cpsel;
  logic                         pix_ready;
  logic                         pix_valid;
  logic [NUM_CP*DATA_WIDTH-1:0] pix_data;

  modport master (
    output inpvalid, din, cpsel, pix_ready,
    input  pix_valid, pix_data
  );

  modport slave (
    input  inpvalid, din, cpsel, pix_ready,
    output pix_valid, pix_data
  );

endinterface

// File: rtl/gamma_plane_packer_pix_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head word.
// A push into a full FIFO is ignored unless a pop happens in the same cycle.
module gamma_plane_packer_pix_sync_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
    end
  end

  // Head register tracks the entry at the post-pop read pointer; when that
  // slot is being written this cycle the incoming word goes straight in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
      rdata <= wdata;
    end else if (do_pop) begin
      rdata <= mem[rd_next[AW-1:0]];
    end
  end

endmodule

// File: rtl/gamma_plane_packer.sv
// Reassembles serial colour planes into parallel pixels, queues them in a
// pixel FIFO and flags plane-order errors and dropped pixels.
//
//   state       | meaning
//   ASM_IDLE    | waiting for plane 0 of a new pixel
//   ASM_COLLECT | plane 0..k-1 held, expecting plane k (k_q)
module gamma_plane_packer
  import gamma_plane_packer_pkg::*;
#(
  parameter int DATA_WIDTH  = GPP_DATA_WIDTH,
  parameter int NUM_CP      = GPP_NUM_CP,
  parameter int CPSEL_WIDTH = GPP_CPSEL_WIDTH,
  parameter int FIFO_DEPTH  = GPP_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ce,
  input  logic                          ovf_clr,
  gamma_plane_packer_if.slave           bus,
  output logic                          seq_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int PIX_W  = pix_width(NUM_CP, DATA_WIDTH);
  localparam int PART_W = (NUM_CP - 1) * DATA_WIDTH;

  localparam logic [CPSEL_WIDTH-1:0] IDX_FIRST  = CPSEL_WIDTH'(CP0);
  localparam logic [CPSEL_WIDTH-1:0] IDX_SECOND = CPSEL_WIDTH'(CP1);
  localparam logic [CPSEL_WIDTH-1:0] IDX_LAST   = CPSEL_WIDTH'(NUM_CP - 1);

  asm_state_e             state_q;
  asm_state_e             state_d;
  logic [CPSEL_WIDTH-1:0] k_q;
  logic [CPSEL_WIDTH-1:0] k_d;
  logic                   plane_vld;
  logic                   latch;
  logic                   push;
  logic [PART_W-1:0]      partial_q;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   drop;
  logic [PIX_W-1:0]       fifo_rdata;

  assign plane_vld = ce & bus.inpvalid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ASM_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    latch   = 1'b0;
    push    = 1'b0;
    seq_err = 1'b0;
    if (plane_vld) begin
      case (state_q)
        ASM_IDLE: begin
          if (bus.cpsel == IDX_FIRST) begin
            latch   = 1'b1;
            state_d = ASM_COLLECT;
            k_d     = IDX_SECOND;
          end else begin
            seq_err = 1'b1;
          end
        end
        default: begin
          if (bus.cpsel == k_q) begin
            if (k_q == IDX_LAST) begin
              push    = 1'b1;
              state_d = ASM_IDLE;
              k_d     = '0;
            end else begin
              latch = 1'b1;
              k_d   = k_q + 1'b1;
            end
          end else if (bus.cpsel == IDX_FIRST) begin
            // Out-of-order plane 0 starts a fresh pixel rather than being lost.
            seq_err = 1'b1;
            latch   = 1'b1;
            k_d     = IDX_SECOND;
          end else begin
            seq_err = 1'b1;
            state_d = ASM_IDLE;
            k_d     = '0;
          end
        end
      endcase
    end
  end

  // Only planes 0..NUM_CP-2 are stored; the last plane joins the push directly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      partial_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CP - 1; i++) begin
        if (latch && (bus.cpsel == CPSEL_WIDTH'(i))) begin
          partial_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.din;
        end
      end
    end
  end

  assign fifo_pop = ce & bus.pix_ready & ~fifo_empty;
  assign drop     = push & fifo_full & ~fifo_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ce && ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  gamma_plane_packer_pix_sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (fifo_pop),
    .wdata ({bus.din, partial_q}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill)
  );

  assign bus.pix_valid = ~fifo_empty;
  assign bus.pix_data  = fifo_rdata;

endmodule
